// File: rtl/game_369_checker.sv
// Sequence checker for the 369 game counter: validates 0,3,6,9,13,6,9,13,...,
// emits clap pulses, keeps saturating statistics and a sticky fault.
// Optional macro GAME_369_AUTO_RESYNC_EN lets FAULT re-enter RUN on a clap value.
module game_369_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [3:0]       count,
  output logic             clap,
  output logic [3:0]       expected,
  output logic [1:0]       state,
  output logic             fault,
  output logic [3:0]       err_value,
  output logic [CNT_W-1:0] clap_total,
  output logic [CNT_W-1:0] loop_total
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       expected_q, expected_d;
  logic             clap_q, clap_d;
  logic             fault_q, fault_d;
  logic [3:0]       err_value_q, err_value_d;
  logic [CNT_W-1:0] clap_total_q, clap_total_d;
  logic [CNT_W-1:0] loop_total_q, loop_total_d;
  logic             last13_q, last13_d;

  function automatic logic [3:0] nxt(input logic [3:0] v);
    case (v)
      4'd0:    nxt = 4'd3;
      4'd3:    nxt = 4'd6;
      4'd6:    nxt = 4'd9;
      4'd9:    nxt = 4'd13;
      4'd13:   nxt = 4'd6;
      default: nxt = 4'd0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Next-state and output decode; clap defaults low so it is a one-cycle pulse.
  always_comb begin
    state_d      = state_q;
    expected_d   = expected_q;
    clap_d       = 1'b0;
    fault_d      = fault_q;
    err_value_d  = err_value_q;
    clap_total_d = clap_total_q;
    loop_total_d = loop_total_q;
    last13_d     = last13_q;
    if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (count == 4'd0) begin
            state_d    = ST_RUN;
            expected_d = 4'd3;
            last13_d   = 1'b0;
          end else begin
            state_d     = ST_FAULT;
            fault_d     = 1'b1;
            err_value_d = count;
          end
        end
        ST_RUN: begin
          if (count == expected_q) begin
            expected_d   = nxt(count);
            clap_d       = 1'b1;
            clap_total_d = sat_inc(clap_total_q);
            if (count == 4'd6 && last13_q) begin
              loop_total_d = sat_inc(loop_total_q);
            end else begin
              loop_total_d = loop_total_q;
            end
            last13_d = (count == 4'd13);
          end else begin
            state_d     = ST_FAULT;
            fault_d     = 1'b1;
            err_value_d = count;
          end
        end
        ST_FAULT: begin
`ifdef GAME_369_AUTO_RESYNC_EN
          // Resync keeps fault/err_value sticky; only a clap value re-enters RUN.
          if (count == 4'd3 || count == 4'd6 || count == 4'd9 || count == 4'd13) begin
            state_d      = ST_RUN;
            expected_d   = nxt(count);
            clap_d       = 1'b1;
            clap_total_d = sat_inc(clap_total_q);
            last13_d     = (count == 4'd13);
          end else begin
            state_d = ST_FAULT;
          end
`else
          state_d = ST_FAULT;
`endif
        end
        default: begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end
      endcase
    end else begin
      clap_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      expected_q   <= 4'd0;
      clap_q       <= 1'b0;
      fault_q      <= 1'b0;
      err_value_q  <= 4'd0;
      clap_total_q <= '0;
      loop_total_q <= '0;
      last13_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      expected_q   <= expected_d;
      clap_q       <= clap_d;
      fault_q      <= fault_d;
      err_value_q  <= err_value_d;
      clap_total_q <= clap_total_d;
      loop_total_q <= loop_total_d;
      last13_q     <= last13_d;
    end
  end

  assign clap       = clap_q;
  assign expected   = expected_q;
  assign state      = state_q;
  assign fault      = fault_q;
  assign err_value  = err_value_q;
  assign clap_total = clap_total_q;
  assign loop_total = loop_total_q;

endmodule

// File: tb/tb_game_369_checker.sv
// Scoreboard bench for game_369_checker: a reference model pushes expected
// outputs per driven cycle; they are popped and compared one edge later.
module tb_game_369_checker;

  logic       clk = 1'b0;
  logic       reset, enable;
  logic [3:0] count;

  logic       clap, fault;
  logic [3:0] expected, err_value;
  logic [1:0] state;
  logic [7:0] clap_total, loop_total;

  logic       clap2, fault2;
  logic [3:0] expected2, err_value2;
  logic [1:0] state2;
  logic [1:0] clap_total2, loop_total2;

  always #5 clk = ~clk;

  game_369_checker #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .count(count),
    .clap(clap), .expected(expected), .state(state), .fault(fault),
    .err_value(err_value), .clap_total(clap_total), .loop_total(loop_total)
  );

  game_369_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .count(count),
    .clap(clap2), .expected(expected2), .state(state2), .fault(fault2),
    .err_value(err_value2), .clap_total(clap_total2), .loop_total(loop_total2)
  );

  typedef struct {
    int clap, expected, state, fault, err, ct8, lt8, ct2, lt2;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // reference model state
  int m_state, m_exp, m_clap, m_fault, m_err, m_ct8, m_lt8, m_ct2, m_lt2;
  bit m_last13;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic int succ(input int v);
    if (v == 0) return 3;
    if (v == 3) return 6;
    if (v == 6) return 9;
    if (v == 9) return 13;
    return 6;
  endfunction

  function automatic bit is_clap_val(input int v);
    return (v == 3) || (v == 6) || (v == 9) || (v == 13);
  endfunction

  task automatic bump_clap();
    m_ct8 = (m_ct8 == 255) ? 255 : m_ct8 + 1;
    m_ct2 = (m_ct2 == 3) ? 3 : m_ct2 + 1;
  endtask

  task automatic model(input bit r, input bit en, input int c);
    if (r) begin
      m_state = 0; m_exp = 0; m_clap = 0; m_fault = 0; m_err = 0;
      m_ct8 = 0; m_lt8 = 0; m_ct2 = 0; m_lt2 = 0; m_last13 = 0;
    end else begin
      m_clap = 0;
      if (en) begin
        if (m_state == 0) begin
          if (c == 0) begin m_state = 1; m_exp = 3; m_last13 = 0; end
          else begin m_state = 2; m_fault = 1; m_err = c; end
        end else if (m_state == 1) begin
          if (c == m_exp) begin
            m_clap = 1; m_exp = succ(c); bump_clap();
            if (c == 6 && m_last13) begin
              m_lt8 = (m_lt8 == 255) ? 255 : m_lt8 + 1;
              m_lt2 = (m_lt2 == 3) ? 3 : m_lt2 + 1;
            end
            m_last13 = (c == 13);
          end else begin
            m_state = 2; m_fault = 1; m_err = c;
          end
        end else begin
`ifdef GAME_369_AUTO_RESYNC_EN
          if (is_clap_val(c)) begin
            m_state = 1; m_exp = succ(c); m_clap = 1; bump_clap();
            m_last13 = (c == 13);
          end
`endif
        end
      end
    end
  endtask

  // drive on negedge, push model result, compare #1 after the sampling edge
  task automatic step(input bit r, input bit en, input int c);
    exp_t e;
    @(negedge clk);
    reset = r; enable = en; count = 4'(c);
    model(r, en, c);
    e.clap = m_clap; e.expected = m_exp; e.state = m_state; e.fault = m_fault;
    e.err = m_err; e.ct8 = m_ct8; e.lt8 = m_lt8; e.ct2 = m_ct2; e.lt2 = m_lt2;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("clap", int'(clap), e.clap);
    check_eq("expected", int'(expected), e.expected);
    check_eq("state", int'(state), e.state);
    check_eq("fault", int'(fault), e.fault);
    check_eq("err_value", int'(err_value), e.err);
    check_eq("clap_total", int'(clap_total), e.ct8);
    check_eq("loop_total", int'(loop_total), e.lt8);
    check_eq("clap_total_w2", int'(clap_total2), e.ct2);
    check_eq("loop_total_w2", int'(loop_total2), e.lt2);
  endtask

  int seq1[9] = '{0, 3, 6, 9, 13, 6, 9, 13, 6};

  initial begin
    reset = 1'b1; enable = 1'b0; count = 4'd0;

    // legal stream with two loops
    step(1'b1, 1'b0, 0);
    check_eq("rst_state", int'(state), 0);
    check_eq("rst_clap_total", int'(clap_total), 0);
    foreach (seq1[i]) begin
      step(1'b0, 1'b1, seq1[i]);
      check_eq("seq_clap", int'(clap), (i == 0) ? 0 : 1);
    end
    check_eq("seq_clap_total", int'(clap_total), 8);
    check_eq("seq_loop_total", int'(loop_total), 2);
    check_eq("seq_expected", int'(expected), 9);
    check_eq("seq_fault", int'(fault), 0);
    check_eq("sat_clap_total_w2", int'(clap_total2), 3);
    check_eq("sat_loop_total_w2", int'(loop_total2), 2'd3 & 2);

    // illegal first sample
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 3);
    check_eq("first3_err", int'(err_value), 3);
    check_eq("first3_fault", int'(fault), 1);

    // mid-stream fault, then samples that would resync
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b1, 3);
    step(1'b0, 1'b1, 7);
    check_eq("f7_err", int'(err_value), 7);
    check_eq("f7_expected", int'(expected), 6);
    check_eq("f7_clap_total", int'(clap_total), 1);
    step(1'b0, 1'b1, 9);
`ifdef GAME_369_AUTO_RESYNC_EN
    check_eq("resync_state", int'(state), 1);
    check_eq("resync_expected", int'(expected), 13);
    check_eq("resync_clap", int'(clap), 1);
`else
    check_eq("frozen_state", int'(state), 2);
    check_eq("frozen_clap", int'(clap), 0);
`endif
    step(1'b0, 1'b1, 13);
    check_eq("sticky_fault", int'(fault), 1);
    check_eq("sticky_err", int'(err_value), 7);

    // enable gaps with count held at an out-of-sequence value
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b1, 3);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 9);
    step(1'b0, 1'b1, 6);
    check_eq("gap_clap_total", int'(clap_total), 2);
    check_eq("gap_fault", int'(fault), 0);

    // narrow counters: 0,3,6,9,13,6 saturates clap_total at 3
    step(1'b1, 1'b0, 0);
    foreach (seq1[i]) if (i < 6) step(1'b0, 1'b1, seq1[i]);
    check_eq("w2_clap_total", int'(clap_total2), 3);
    check_eq("w2_loop_total", int'(loop_total2), 1);

    // reset dominates a concurrent enabled sample
    step(1'b1, 1'b1, 13);
    check_eq("rst_dom_state", int'(state2), 0);
    check_eq("rst_dom_clap_total", int'(clap_total2), 0);

    // random stress against the model
    for (int k = 0; k < 200; k++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           (($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : m_exp));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/game_369_checker.md
Name: game_369_checker

Overview:
- Downstream consumer of the 369 game counter's 4-bit count.
- Samples each count value, checks it against the legal sequence 0, 3, 6, 9, 13, 6, 9, 13, 6, …
- Emits a registered clap pulse for every legal "clap" value and keeps clap and loop statistics.
- Latches a sticky fault on the first illegal value; the fault feeds board LEDs and the lab self-check.

Parameters:
CNT_W, 8, width of the saturating clap_total and loop_total counters (legal 2..16)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset; one clock; dominates every other input
enable  input  1  count is sampled on this edge when high; ignored when low
count  input  4  current counter value from the 369 counter
clap  output  1  one-cycle pulse: last sampled value was legal and in {3,6,9,13}
expected  output  4  value the next enabled sample must equal
state  output  2  0=IDLE, 1=RUN, 2=FAULT (3 unused)
fault  output  1  sticky: an illegal value has been sampled since reset
err_value  output  4  first offending count value
clap_total  output  CNT_W  number of clap pulses since reset, saturating at all-ones
loop_total  output  CNT_W  number of legal 13->6 transitions since reset, saturating

Behaviour:
- All outputs are registered; response appears on the edge that samples count (1-cycle latency).
- Reset values:
  - clap=0, expected=0, state=IDLE, fault=0, err_value=0, clap_total=0, loop_total=0.
  - Reset asserted mid-run clears all of the above on that edge, regardless of enable.
- Successor function nxt(v): 0->3, 3->6, 6->9, 9->13, 13->6; undefined for any other v.
- enable=0:
  - State, expected, err_value and counters hold.
  - clap=0.
- IDLE, enable=1:
  - count==0: go to RUN, expected<=3, clap<=0.
  - Otherwise: go to FAULT, fault<=1, err_value<=count.
- RUN, enable=1:
  - count==expected: stay in RUN, expected<=nxt(count), clap<=1 (every legal RUN value is a clap value).
    - clap_total increments unless already all-ones.
    - If count==6 and the previous legal value was 13, loop_total increments (saturating).
  - count!=expected: go to FAULT, fault<=1, err_value<=count, clap<=0; expected holds.
- FAULT:
  - Absorbing until reset; clap=0; counters, err_value and expected frozen.
  - fault stays 1 (see Optional Feature for the exception).
- Saturation: at all-ones, an increment event leaves the counter at all-ones without wrapping.
- Back-to-back enables every cycle are supported; no throughput gaps.
- Values 1,2,4,5,7,8,10,11,12,14,15 are never legal.
- 0 is legal only as the first sample after reset.

Optional Feature:
- Macro: GAME_369_AUTO_RESYNC_EN.
- Defined: in FAULT with enable=1 and count in {3,6,9,13}, go to RUN with expected<=nxt(count).
  - clap pulses and counters resume from that sample.
  - The resync sample itself produces clap=1 and increments clap_total.
  - fault and err_value remain sticky (first error kept).
  - count==0 or any non-legal value keeps the block in FAULT.
- Undefined: FAULT is absorbing until reset, as described above.

Test Plan:
- Reset, then enable with count stream 0,3,6,9,13,6,9,13,6.
  - -> clap pulses 0,1,1,1,1,1,1,1,1.
  - -> final clap_total=8, loop_total=2, expected=9, fault=0, state=RUN.
- Reset, first sample count=3 -> state=FAULT, fault=1, err_value=3, clap=0, clap_total=0.
- Stream 0,3,7 -> fault=1, err_value=7, expected frozen at 6, clap_total=1.
  - Further samples 9,13 -> no clap, counters unchanged (macro undefined).
  - With GAME_369_AUTO_RESYNC_EN: 9 resyncs -> clap=1, expected=13, state=RUN, fault stays 1.
- Stream 0,3,6 with enable low for 3 cycles between 3 and 6 (count held at 9 meanwhile).
  - -> no fault, no clap during gaps, clap_total=2.
- CNT_W=2: run 0,3,6,9,13,6 -> clap_total saturates at 3, loop_total=1.
  - Reset asserted together with enable=1, count=13 -> all outputs at reset values next edge.
